// File: rtl/lms_pkg.sv
// Shared types and default sizing for the LMS convergence monitor.
// Used by lms_sq_window and lms_conv_monitor.
package lms_pkg;

  localparam int LMS_WIDTH    = 8;
  localparam int LMS_TAPS     = 4;
  localparam int LMS_WIN_LOG2 = 4;
  localparam int LMS_HOLD     = 3;

  typedef logic signed [LMS_WIDTH-1:0] sample_t;
  typedef logic [2*LMS_WIDTH-1:0]      sq_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACQUIRE   = 2'd1,
    CONVERGED = 2'd2,
    DIVERGED  = 2'd3
  } conv_state_t;

endpackage

// File: rtl/lms_sq_window.sv
// Error squarer plus windowed accumulator; presents the truncated window mean
// and a done strobe in the cycle the last square is folded in.
module lms_sq_window
  import lms_pkg::*;
#(
  parameter int WIDTH    = LMS_WIDTH,
  parameter int WIN_LOG2 = LMS_WIN_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 e_valid,
  input  logic [WIDTH-1:0]     e_in,
  output logic [2*WIDTH-1:0]   mse,
  output logic                 done
);

  localparam int SQ_W  = 2 * WIDTH;
  localparam int ACC_W = SQ_W + WIN_LOG2;

  function automatic logic [SQ_W-1:0] mse_trunc(input logic [ACC_W-1:0] sum);
    return SQ_W'(sum >> WIN_LOG2);
  endfunction

  logic signed [SQ_W-1:0] w_ext;
  logic signed [SQ_W-1:0] w_prod;
  logic [ACC_W-1:0]       w_sum;
  logic                   w_last;

  logic [SQ_W-1:0]        r_sq_p1;
  logic                   r_vld_p1;
  logic [ACC_W-1:0]       r_acc_p2;
  logic [WIN_LOG2-1:0]    r_cnt_p2;

  // The square of the most negative sample still fits in 2*WIDTH bits.
  assign w_ext  = {{WIDTH{e_in[WIDTH-1]}}, e_in};
  assign w_prod = w_ext * w_ext;

  assign w_sum  = r_acc_p2 + ACC_W'(r_sq_p1);
  assign w_last = r_vld_p1 && (r_cnt_p2 == '1);

  // p0 -> p1: square the incoming sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sq_p1  <= '0;
      r_vld_p1 <= 1'b0;
    end else if (clear) begin
      r_sq_p1  <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= e_valid;
      if (e_valid) r_sq_p1 <= w_prod;
    end
  end

  // p1 -> p2: accumulate; the closing sample restarts the window at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_p2 <= '0;
      r_cnt_p2 <= '0;
    end else if (clear) begin
      r_acc_p2 <= '0;
      r_cnt_p2 <= '0;
    end else if (r_vld_p1) begin
      r_cnt_p2 <= r_cnt_p2 + WIN_LOG2'(1);
      r_acc_p2 <= w_last ? '0 : w_sum;
    end
  end

  assign mse  = mse_trunc(w_sum);
  assign done = w_last;

endmodule

// File: rtl/lms_conv_monitor.sv
// Windowed-MSE convergence/divergence monitor for the LMS filter core.
// Define CONV_MON_SNAPSHOT_EN to capture the weights on each entry to CONVERGED.
module lms_conv_monitor
  import lms_pkg::*;
#(
  parameter int WIDTH    = LMS_WIDTH,
  parameter int TAPS     = LMS_TAPS,
  parameter int WIN_LOG2 = LMS_WIN_LOG2,
  parameter int HOLD     = LMS_HOLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    e_valid,
  input  logic [WIDTH-1:0]        e_in,
  input  logic [2*WIDTH-1:0]      thresh,
  input  logic [TAPS*WIDTH-1:0]   weights,
  output logic [2*WIDTH-1:0]      mse_out,
  output logic                    mse_valid,
  output logic                    converged,
  output logic                    diverged,
  output logic [15:0]             win_count,
  output logic [TAPS*WIDTH-1:0]   snap_weights,
  output logic                    snap_valid
);

  localparam int CMP_W = 2 * WIDTH + 2;
  localparam int CNT_W = $clog2(HOLD + 1);

  logic [2*WIDTH-1:0] w_mse;
  logic               w_done;
  logic [CMP_W-1:0]   w_mse_c, w_th1, w_th2, w_th4;
  logic               w_low, w_high, w_bad;
  conv_state_t        w_state_n;
  logic [CNT_W-1:0]   w_low_n, w_bad_n;

  conv_state_t        r_state;
  logic [CNT_W-1:0]   r_low_cnt, r_bad_cnt;
  logic [2*WIDTH-1:0] r_mse;
  logic               r_mse_vld;
  logic               r_conv, r_div;
  logic [15:0]        r_win_cnt;

  lms_sq_window #(
    .WIDTH    (WIDTH),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .e_valid (e_valid),
    .e_in    (e_in),
    .mse     (w_mse),
    .done    (w_done)
  );

  // Two guard bits keep 4*thresh from wrapping.
  assign w_mse_c = {2'b00, w_mse};
  assign w_th1   = {2'b00, thresh};
  assign w_th2   = {1'b0, thresh, 1'b0};
  assign w_th4   = {thresh, 2'b00};
  assign w_low   = (w_mse_c <= w_th1);
  assign w_high  = (w_mse_c >  w_th2);
  assign w_bad   = (w_mse_c >= w_th4);

  always_comb begin
    w_state_n = r_state;
    w_low_n   = r_low_cnt;
    w_bad_n   = r_bad_cnt;
    if (r_state == IDLE && e_valid) w_state_n = ACQUIRE;
    if (w_done && r_state != DIVERGED) begin
      w_bad_n = w_bad ? r_bad_cnt + CNT_W'(1) : '0;
      if (r_state == ACQUIRE) begin
        w_low_n = w_low ? r_low_cnt + CNT_W'(1) : '0;
        if (w_low_n == CNT_W'(HOLD)) w_state_n = CONVERGED;
      end else if (r_state == CONVERGED && w_high) begin
        w_state_n = ACQUIRE;
        w_low_n   = '0;
      end
      // Divergence overrides any other decision in the same window.
      if (w_bad_n == CNT_W'(HOLD)) w_state_n = DIVERGED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_low_cnt <= '0;
      r_bad_cnt <= '0;
      r_mse     <= '0;
      r_mse_vld <= 1'b0;
      r_conv    <= 1'b0;
      r_div     <= 1'b0;
      r_win_cnt <= '0;
    end else if (clear) begin
      r_state   <= IDLE;
      r_low_cnt <= '0;
      r_bad_cnt <= '0;
      r_mse     <= '0;
      r_mse_vld <= 1'b0;
      r_conv    <= 1'b0;
      r_div     <= 1'b0;
      r_win_cnt <= '0;
    end else begin
      r_state   <= w_state_n;
      r_low_cnt <= w_low_n;
      r_bad_cnt <= w_bad_n;
      r_mse_vld <= w_done;
      r_conv    <= (w_state_n == CONVERGED);
      r_div     <= (w_state_n == DIVERGED);
      if (w_done) r_mse <= w_mse;
      if (w_done && r_win_cnt != 16'hFFFF) r_win_cnt <= r_win_cnt + 16'd1;
    end
  end

  assign mse_out   = r_mse;
  assign mse_valid = r_mse_vld;
  assign converged = r_conv;
  assign diverged  = r_div;
  assign win_count = r_win_cnt;

`ifdef CONV_MON_SNAPSHOT_EN
  logic                  w_enter;
  logic                  r_snap_vld;
  logic [TAPS*WIDTH-1:0] r_snap_w;

  assign w_enter = (w_state_n == CONVERGED) && (r_state != CONVERGED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap_vld <= 1'b0;
      r_snap_w   <= '0;
    end else if (clear) begin
      r_snap_vld <= 1'b0;
      r_snap_w   <= '0;
    end else begin
      r_snap_vld <= w_enter;
      if (w_enter) r_snap_w <= weights;
    end
  end

  assign snap_weights = r_snap_w;
  assign snap_valid   = r_snap_vld;
`else
  logic w_unused_weights;
  assign w_unused_weights = ^weights;
  assign snap_weights     = '0;
  assign snap_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_lms_conv_monitor.sv
// Randomized bench for lms_conv_monitor with an integer reference model and
// directed literal checks; honours CONV_MON_SNAPSHOT_EN like the design.
module tb_lms_conv_monitor;

  localparam int HOLD = 3;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        clear   = 1'b0;
  logic        e_valid = 1'b0;
  logic [7:0]  e_in    = '0;
  logic [15:0] thresh  = '0;
  logic [31:0] weights = '0;
  logic [15:0] mse_out;
  logic        mse_valid;
  logic        converged;
  logic        diverged;
  logic [15:0] win_count;
  logic [31:0] snap_weights;
  logic        snap_valid;

  int checks = 0;
  int errors = 0;

  lms_conv_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .e_valid      (e_valid),
    .e_in         (e_in),
    .thresh       (thresh),
    .weights      (weights),
    .mse_out      (mse_out),
    .mse_valid    (mse_valid),
    .converged    (converged),
    .diverged     (diverged),
    .win_count    (win_count),
    .snap_weights (snap_weights),
    .snap_valid   (snap_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: states 0 idle, 1 acquire, 2 converged, 3 diverged.
  int          m_state = 0, m_low = 0, m_bad = 0, m_sum = 0, m_n = 0;
  int          m_pend = 0, m_pmse = 0;
  int          exp_mse = 0, exp_mv = 0, exp_wc = 0, exp_sv = 0;
  logic [31:0] exp_sw = '0;

  task automatic model_reset();
    m_state = 0; m_low = 0; m_bad = 0; m_sum = 0; m_n = 0;
    m_pend = 0; m_pmse = 0;
    exp_mse = 0; exp_mv = 0; exp_wc = 0; exp_sv = 0; exp_sw = '0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      model_reset();
    end else begin
      exp_mv = 0;
      exp_sv = 0;
      if (m_pend != 0) begin
        int prev, m, t;
        prev = m_state; m = m_pmse; t = int'(thresh);
        exp_mse = m; exp_mv = 1;
        if (exp_wc < 65535) exp_wc++;
        if (m_state != 3) begin
          m_bad = (m >= 4 * t) ? m_bad + 1 : 0;
          if (m_state == 1) begin
            m_low = (m <= t) ? m_low + 1 : 0;
            if (m_low == HOLD) m_state = 2;
          end else if (m_state == 2 && m > 2 * t) begin
            m_state = 1;
            m_low   = 0;
          end
          if (m_bad == HOLD) m_state = 3;
        end
`ifdef CONV_MON_SNAPSHOT_EN
        if (m_state == 2 && prev != 2) begin
          exp_sv = 1;
          exp_sw = weights;
        end
`endif
        m_pend = 0;
      end
      if (e_valid) begin
        int ev;
        ev = int'($signed(e_in));
        if (m_state == 0) m_state = 1;
        m_sum += ev * ev;
        m_n++;
        if (m_n == 16) begin
          m_pend = 1;
          m_pmse = m_sum / 16;
          m_sum  = 0;
          m_n    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mse_out",      mse_out,      exp_mse);
    chk("mse_valid",    mse_valid,    exp_mv);
    chk("converged",    converged,    (m_state == 2));
    chk("diverged",     diverged,     (m_state == 3));
    chk("win_count",    win_count,    exp_wc);
    chk("snap_valid",   snap_valid,   exp_sv);
    chk("snap_weights", snap_weights, exp_sw);
  end

  task automatic cyc(input logic v, input int e, input logic clr, input logic r = 1'b1);
    @(posedge clk);
    #2;
    rst     = r;
    e_valid = v;
    e_in    = 8'(e);
    clear   = clr;
  endtask

  task automatic send_window(input int e);
    for (int i = 0; i < 16; i++) cyc(1'b1, e, 1'b0);
  endtask

  task automatic wait_mse(input int maxc, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      cyc(1'b0, 0, 1'b0);
      @(negedge clk);
      if (mse_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit found;
    int emax, mode, len, e;

    // Reset held with e_valid toggling
    thresh = 16'd4;
    for (int i = 0; i < 6; i++) cyc(1'(i % 2), 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mse_valid", mse_valid, 0);
    chk("rst_mse_out",   mse_out,   0);
    chk("rst_win_count", win_count, 0);
    chk("rst_converged", converged, 0);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // e=2, thresh=4: converge on third window, snapshot taken
    weights = 32'h04030201;
    for (int w = 0; w < 3; w++) begin
      send_window(2);
      wait_mse(6, found);
      chk("c2_found", found, 1);
      chk("c2_mse", mse_out, 4);
      if (w < 2) chk("c2_not_conv", converged, 0);
    end
    chk("c2_conv", converged, 1);
    chk("c2_wc", win_count, 3);
`ifdef CONV_MON_SNAPSHOT_EN
    chk("c6_snap_valid", snap_valid, 1);
    chk("c6_snap_w", snap_weights, 32'h04030201);
`else
    chk("c6_snap_off", snap_valid, 0);
`endif
    weights = 32'hAABBCCDD;
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0);
    @(negedge clk);
`ifdef CONV_MON_SNAPSHOT_EN
    chk("c6_snap_hold", snap_weights, 32'h04030201);
`else
    chk("c6_snap_zero", snap_weights, 0);
`endif

    // One noisy window drops convergence, three clean ones restore it
    send_window(5);
    wait_mse(6, found);
    chk("c4_found", found, 1);
    chk("c4_mse", mse_out, 25);
    chk("c4_drop", converged, 0);
    for (int w = 0; w < 3; w++) begin
      send_window(2);
      wait_mse(6, found);
      chk("c4_found2", found, 1);
      if (w < 2) chk("c4_not_yet", converged, 0);
    end
    chk("c4_reconv", converged, 1);
    chk("c4_wc", win_count, 7);

    // Full-scale negative error diverges and stays diverged
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b0);
    @(negedge clk);
    chk("clr_wc", win_count, 0);
    chk("clr_conv", converged, 0);
    thresh = 16'd100;
    for (int w = 0; w < 4; w++) begin
      send_window((w < 3) ? -128 : 0);
      wait_mse(6, found);
      chk("c3_found", found, 1);
      chk("c3_mse", mse_out, (w < 3) ? 16384 : 0);
      chk("c3_div", diverged, (w >= 2));
      chk("c3_conv", converged, 0);
    end

    // Clear flushes a partial window; the coincident sample is dropped
    cyc(1'b0, 0, 1'b1);
    thresh = 16'd4;
    for (int i = 0; i < 6; i++) cyc(1'b1, 9, 1'b0);
    cyc(1'b1, 9, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 2, 1'b0);
      repeat ($urandom_range(1, 3)) cyc(1'b0, 0, 1'b0);
    end
    wait_mse(4, found);
    chk("c5_no_early", found, 0);
    cyc(1'b1, 2, 1'b0);
    wait_mse(6, found);
    chk("c5_found", found, 1);
    chk("c5_mse", mse_out, 4);
    chk("c5_wc", win_count, 1);

    // Randomized traffic with gaps, clears, resets and threshold changes
    for (int seg = 0; seg < 80; seg++) begin
      thresh = 16'($urandom_range(0, 60));
      mode   = $urandom_range(0, 3);
      emax   = (mode == 0) ? 2 : (mode == 1) ? 6 : 128;
      len    = $urandom_range(16, 70);
      e      = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) weights = $urandom;
      for (int i = 0; i < len; i++) begin
        int ev;
        if (mode == 3) ev = e;
        else if (mode == 2) ev = int'($urandom_range(0, 255)) - 128;
        else ev = int'($urandom_range(0, 2 * emax)) - emax;
        cyc(1'($urandom_range(0, 3) != 0), ev,
            1'($urandom_range(0, 149) == 0),
            1'($urandom_range(0, 249) != 0));
      end
    end
    cyc(1'b0, 0, 1'b0);
    repeat (4) cyc(1'b0, 0, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
